aes_key_sched: RTL and testbench

AES_KEY_SCHED -- requirements
Module: aes_key_sched

---
 rtl/aes_pkg.sv | 52 +++++
 rtl/aes_sbox_word.sv | 47 ++++
 rtl/aes_key_sched.sv | 157 +++++++++++++++
 tb/tb_aes_key_sched.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared constants for the AES key schedule: key-length encoding, per-length
// Nk/Nr/word-count lookups and the GF(2^8) doubling helper.
package aes_pkg;

    localparam int unsigned MAX_WORDS = 60;
    localparam int unsigned WIDX_W    = 6;
    localparam int unsigned KEY_W     = 256;
    localparam int unsigned RK_W      = 128;

    typedef enum logic [1:0] {
        KL_128 = 2'b00,
        KL_192 = 2'b01,
        KL_256 = 2'b10,
        KL_BAD = 2'b11
    } key_len_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXPAND,
        S_DONE
    } state_e;

    function automatic logic [3:0] nk_of(input logic [1:0] kl);
        case (kl)
            KL_192:  return 4'd6;
            KL_256:  return 4'd8;
            default: return 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] kl);
        case (kl)
            KL_192:  return 4'd12;
            KL_256:  return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

    function automatic logic [WIDX_W-1:0] nwords_of(input logic [1:0] kl);
        case (kl)
            KL_192:  return WIDX_W'(52);
            KL_256:  return WIDX_W'(60);
            default: return WIDX_W'(44);
        endcase
    endfunction

    // Multiply by x in GF(2^8) modulo 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// Four parallel AES S-boxes, computed as GF(2^8) inverse followed by the
// affine transform rather than a lookup table.
module aes_sbox_word
    import aes_pkg::*;
(
    input  logic [31:0] din,
    output logic [31:0] dout
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 == a^-1 for a != 0, and maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = a;
        for (int k = 1; k < 8; k++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] v;
        v = gf_inv(b);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                 ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    always_comb begin
        dout = '0;
        for (int j = 0; j < 4; j++) dout[8*j +: 8] = sbox(din[8*j +: 8]);
    end

endmodule

// File: rtl/aes_key_sched.sv
// AES-128/192/256 key expansion: one schedule word per cycle into a 60-word
// store, with a round-key read port (optionally registered).
module aes_key_sched
    import aes_pkg::*;
#(
    parameter int unsigned REG_RD = 0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [1:0]       key_len_i,
    input  logic [KEY_W-1:0] key_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    input  logic [3:0]       rk_idx_i,
    output logic [RK_W-1:0]  rk_o,
    output logic             rk_valid_o
);

    state_e            state;
    logic [1:0]        mode;
    logic [WIDX_W-1:0] widx;
    logic [2:0]        kmod;
    logic [7:0]        rcon;
    logic              busy;
    logic              done;
    logic              err;
    logic              sched_valid;
    logic [31:0]       wmem [MAX_WORDS];

    logic [3:0]        nk;
    logic [3:0]        nr;
    logic [WIDX_W-1:0] last_idx;
    logic              idle;
    logic              accept;
    logic              reject;
    logic [31:0]       prev_w;
    logic [31:0]       back_w;
    logic [31:0]       sbox_in;
    logic [31:0]       sbox_out;
    logic [31:0]       temp;
    logic [31:0]       new_w;

    assign nk       = nk_of(mode);
    assign nr       = nr_of(mode);
    assign last_idx = nwords_of(mode) - WIDX_W'(1);
    assign idle     = (state == S_IDLE);
    assign accept   = idle && start_i && (key_len_i != KL_BAD);
    assign reject   = idle && start_i && (key_len_i == KL_BAD);

    // Next-word datapath: w[i] = w[i-Nk] ^ f(w[i-1]), kmod tracks i mod Nk.
    assign prev_w  = wmem[widx - WIDX_W'(1)];
    assign back_w  = wmem[widx - WIDX_W'(nk)];
    assign sbox_in = (kmod == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;

    aes_sbox_word u_sbox (
        .din  (sbox_in),
        .dout (sbox_out)
    );

    always_comb begin
        temp = prev_w;
        if (kmod == 3'd0)                          temp = sbox_out ^ {rcon, 24'h000000};
        else if (mode == KL_256 && kmod == 3'd4)   temp = sbox_out;
    end

    assign new_w = back_w ^ temp;

    // Word store is deliberately not reset; sched_valid gates every read.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            for (int k = 0; k < 8; k++) begin
                if (k < int'(nk_of(key_len_i))) wmem[WIDX_W'(k)] <= key_i[KEY_W-1-32*k -: 32];
            end
        end else if (state == S_EXPAND) begin
            wmem[widx] <= new_w;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= S_IDLE;
            mode        <= KL_128;
            widx        <= '0;
            kmod        <= '0;
            rcon        <= 8'h01;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            sched_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        mode        <= key_len_i;
                        widx        <= WIDX_W'(nk_of(key_len_i));
                        kmod        <= '0;
                        rcon        <= 8'h01;
                        busy        <= 1'b1;
                        sched_valid <= 1'b0;
                        state       <= S_EXPAND;
                    end else if (reject) begin
                        err <= 1'b1;
                    end
                end
                S_EXPAND: begin
                    widx <= widx + WIDX_W'(1);
                    kmod <= (kmod == 3'(nk - 4'd1)) ? 3'd0 : kmod + 3'd1;
                    if (kmod == 3'd0) rcon <= xtime(rcon);
                    if (widx == last_idx) begin
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done        <= 1'b1;
                    sched_valid <= 1'b1;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy_o = busy;
    assign done_o = done;
    assign err_o  = err;

    // Round-key read: four consecutive words, zero when out of range or stale.
    logic [WIDX_W-1:0] rd_base;
    logic              rd_ok;
    logic [RK_W-1:0]   rd_data;

    assign rd_base = {rk_idx_i, 2'b00};
    assign rd_ok   = sched_valid && (rk_idx_i <= nr);
    assign rd_data = rd_ok ? {wmem[rd_base], wmem[rd_base + WIDX_W'(1)],
                              wmem[rd_base + WIDX_W'(2)], wmem[rd_base + WIDX_W'(3)]} : '0;

    if (REG_RD != 0) begin : g_reg_rd
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rk_o       <= '0;
                rk_valid_o <= 1'b0;
            end else begin
                rk_o       <= rd_data;
                rk_valid_o <= rd_ok;
            end
        end
    end else begin : g_comb_rd
        assign rk_o       = rd_data;
        assign rk_valid_o = rd_ok;
    end

endmodule

// File: tb/tb_aes_key_sched.sv
// Scoreboard bench for aes_key_sched: combinational and registered read
// variants side by side against a FIPS-197 style reference expansion.
module tb_aes_key_sched;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   key_len;
    logic [255:0] key;
    logic [3:0]   rk_idx;
    logic         busy0, done0, err0, rkv0;
    logic         busy1, done1, err1, rkv1;
    logic [127:0] rk0, rk1;

    always #5 clk = ~clk;

    aes_key_sched #(.REG_RD(0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .key_len_i(key_len), .key_i(key),
        .busy_o(busy0), .done_o(done0), .err_o(err0), .rk_idx_i(rk_idx), .rk_o(rk0),
        .rk_valid_o(rkv0));

    aes_key_sched #(.REG_RD(1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .key_len_i(key_len), .key_i(key),
        .busy_o(busy1), .done_o(done1), .err_o(err1), .rk_idx_i(rk_idx), .rk_o(rk1),
        .rk_valid_o(rkv1));

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic rd_req = 1'b0;
    logic rd_req_d = 1'b0;

    typedef struct { int acc; int lat; } done_t;
    done_t        done_q[$];
    logic [128:0] rd_q0[$];
    logic [128:0] rd_q1[$];
    int           err_q[$];

    // Reference schedule
    logic [31:0] mw [60];
    int          m_nr = 0;
    bit          m_valid = 1'b0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rd_req_d <= rd_req;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] sb(input logic [7:0] b);
        return SBOX[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sb(x[31:24]), sb(x[23:16]), sb(x[15:8]), sb(x[7:0])};
    endfunction

    function automatic logic [7:0] rcon_tbl(input int j);
        case (j)
            1: return 8'h01;  2: return 8'h02;  3: return 8'h04;  4: return 8'h08;
            5: return 8'h10;  6: return 8'h20;  7: return 8'h40;  8: return 8'h80;
            9: return 8'h1b; 10: return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_expand(input logic [1:0] kl, input logic [255:0] k, output int lat);
        int nk;
        logic [31:0] t;
        nk   = 4 + 2*int'(kl);
        m_nr = nk + 6;
        for (int i = 0; i < nk; i++) mw[i] = k[255-32*i -: 32];
        for (int i = nk; i < 4*(m_nr+1); i++) begin
            t = mw[i-1];
            if (i % nk == 0)                 t = subw({t[23:0], t[31:24]}) ^ {rcon_tbl(i/nk), 24'h0};
            else if (nk == 8 && i % nk == 4) t = subw(t);
            mw[i] = mw[i-nk] ^ t;
        end
        lat = 4*(m_nr+1) - nk + 1;
    endtask

    function automatic logic [128:0] exp_rk(input int idx);
        if (!m_valid || idx > m_nr) return '0;
        return {1'b1, mw[4*idx], mw[4*idx+1], mw[4*idx+2], mw[4*idx+3]};
    endfunction

    // Monitor: pops the scoreboard whenever a DUT presents a read, done or error
    always @(negedge clk) begin
        logic [128:0] e;
        done_t d;
        if (rd_req) begin
            if (rd_q0.size() == 0) chk("rd0_unexpected", 128'd1, 128'd0);
            else begin
                e = rd_q0.pop_front();
                chk("rd0_valid", 128'(rkv0), 128'(e[128]));
                chk("rd0_data", rk0, e[127:0]);
            end
        end
        if (rd_req_d) begin
            if (rd_q1.size() == 0) chk("rd1_unexpected", 128'd1, 128'd0);
            else begin
                e = rd_q1.pop_front();
                chk("rd1_valid", 128'(rkv1), 128'(e[128]));
                chk("rd1_data", rk1, e[127:0]);
            end
        end
        if (done0 || done1) begin
            if (done_q.size() == 0) chk("done_unexpected", 128'd1, 128'd0);
            else begin
                d = done_q.pop_front();
                chk("done_latency", 128'(cyc - d.acc), 128'(d.lat));
                chk("done_both", 128'({done0, done1}), 128'(2'b11));
                chk("busy_at_done", 128'({busy0, busy1}), 128'd0);
            end
        end
        if (err0 || err1) begin
            if (err_q.size() == 0) chk("err_unexpected", 128'd1, 128'd0);
            else begin
                void'(err_q.pop_front());
                chk("err_both", 128'({err0, err1}), 128'(2'b11));
            end
        end
    end

    task automatic start_here(input logic [1:0] kl, input logic [255:0] k);
        int lat;
        start   = 1'b1;
        key_len = kl;
        key     = k;
        if (kl != 2'b11) begin
            model_expand(kl, k, lat);
            m_valid = 1'b0;
            done_q.push_back('{acc: cyc + 1, lat: lat});
        end else begin
            err_q.push_back(1);
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic start_run(input logic [1:0] kl, input logic [255:0] k);
        @(posedge clk); #1;
        start_here(kl, k);
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done0 && n < 100);
        if (!done0) chk("done_timeout", 128'd0, 128'd1);
        else m_valid = 1'b1;
    endtask

    task automatic rd_exp(input logic [3:0] idx, input logic v, input logic [127:0] data);
        @(posedge clk); #1;
        rk_idx = idx;
        rd_req = 1'b1;
        rd_q0.push_back({v, data});
        rd_q1.push_back({v, data});
    endtask

    task automatic rd(input logic [3:0] idx);
        logic [128:0] e;
        e = exp_rk(int'(idx));
        rd_exp(idx, e[128], e[127:0]);
    endtask

    task automatic rd_end();
        @(posedge clk); #1;
        rd_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_busy"}, 128'({busy0, busy1}), 128'd0);
        chk({name, "_done"}, 128'({done0, done1}), 128'd0);
        chk({name, "_err"}, 128'({err0, err1}), 128'd0);
        chk({name, "_rkv"}, 128'({rkv0, rkv1}), 128'd0);
        chk({name, "_rk0"}, rk0, 128'd0);
        chk({name, "_rk1"}, rk1, 128'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] rkey;
        rst_n = 1'b0; start = 1'b0; key_len = 2'b00; key = '0; rk_idx = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        rd(4'd0);
        rd_end();

        // Known-answer runs
        start_run(2'b00, KEY128);
        wait_done();
        rd_exp(4'd10, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        rd(4'd0);
        rd_exp(4'd11, 1'b0, 128'h0);
        rd_end();

        start_run(2'b01, KEY192);
        wait_done();
        rd_exp(4'd12, 1'b1, 128'he98ba06f448c773c8ecc720401002202);
        rd_exp(4'd13, 1'b0, 128'h0);
        rd(4'd5);
        rd_end();

        for (int pass = 0; pass < 2; pass++) begin
            start_run(2'b10, KEY256);
            if (pass == 1) begin
                repeat (19) @(posedge clk);
                #1;
                start = 1'b1; key_len = 2'b00; key = {$urandom, $urandom, $urandom, $urandom, 128'h0};
                @(posedge clk); #1;
                start = 1'b0;
            end
            wait_done();
            rd_exp(4'd14, 1'b1, 128'hfe4890d1e6188d0b046df344706c631e);
            rd_exp(4'd1, 1'b1, 128'h1f352c073b6108d72d9810a30914dff4);
            rd_exp(4'd15, 1'b0, 128'h0);
            rd_end();
        end

        // Illegal key length: error pulse, no run, old schedule kept
        start_run(2'b11, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
        repeat (3) begin
            @(negedge clk);
            chk("busy_after_illegal", 128'({busy0, busy1}), 128'd0);
        end
        rd_exp(4'd14, 1'b1, 128'hfe4890d1e6188d0b046df344706c631e);
        rd(4'd7);
        rd_end();

        // Restart in the done cycle
        rk_idx = 4'd0;
        start_run(2'b00, {$urandom, $urandom, $urandom, $urandom, 128'h0});
        wait_done();
        chk("rkv_at_done", 128'(rkv0), 128'd1);
        rkey = {$urandom, $urandom, $urandom, $urandom, 128'h0};
        start_here(2'b00, rkey);
        @(negedge clk);
        chk("rkv_fall_on_restart", 128'(rkv0), 128'd0);
        wait_done();
        rd(4'd10);
        rd(4'd3);
        rd_end();

        // Reset in the middle of an AES-192 run, then a clean AES-128 run
        start_run(2'b01, KEY192);
        repeat (29) @(posedge clk);
        #1;
        rst_n = 1'b0;
        done_q.delete();
        m_valid = 1'b0;
        rk_idx = 4'd0;
        @(negedge clk);
        chk_all_zero("midrun_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        rd(4'd0);
        rd_end();
        start_run(2'b00, KEY128);
        wait_done();
        rd_exp(4'd10, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        rd_end();

        // Randomised keys and lengths
        for (int n = 0; n < 6; n++) begin
            logic [1:0] kl;
            kl   = 2'($urandom_range(0, 2));
            rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            start_run(kl, rkey);
            rd(4'd0);
            rd_end();
            wait_done();
            for (int j = 0; j < 16; j++) rd(4'($urandom_range(0, 15)));
            rd_end();
        end

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("done_q_drained", 128'(done_q.size()), 128'd0);
        chk("err_q_drained", 128'(err_q.size()), 128'd0);
        chk("rd_q_drained", 128'(rd_q0.size() + rd_q1.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
